acc_adder_tree: RTL

ACC_ADDER_TREE -- requirements
Module: acc_adder_tree

---
 rtl/acc_adder_tree_pkg.sv | 15 +
 rtl/acc_adder_tree_stage.sv | 74 +++++++
 rtl/acc_adder_tree.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/acc_adder_tree_pkg.sv
// Shared types and elaboration helpers for the accumulating adder tree.
package acc_adder_tree_pkg;

  typedef struct packed {
    logic sgn;
    logic last;
    logic vld;
  } beat_sb_t;

  function automatic int stage_count(input int layers, input int pipe_every);
    if (layers == 0 || pipe_every < 1) return 0;
    return (layers + pipe_every - 1) / pipe_every;
  endfunction

endpackage

// File: rtl/acc_adder_tree_stage.sv
// A slice of the adder tree: NL pairwise-add layers followed by an optional
// enable-gated register carrying the beat sideband alongside the data.
module acc_adder_tree_stage
  import acc_adder_tree_pkg::*;
#(
  parameter int DATAW   = 8,
  parameter int W       = 10,
  parameter int FIRST   = 0,
  parameter int NL      = 1,
  parameter int NIN     = 4,
  parameter int REG_OUT = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [NIN*W-1:0]          vals_i,
  input  beat_sb_t                  sb_i,
  output logic [(NIN>>NL)*W-1:0]    vals_o,
  output beat_sb_t                  sb_o
);

  localparam int NOUT = NIN >> NL;

  // Operands entering global layer k carry DATAW+k meaningful bits.
  function automatic logic [W-1:0] ext_from(input logic [W-1:0] x, input int w, input logic sgn);
    logic [W-1:0] r;
    r = x;
    for (int i = 0; i < W; i++) begin
      if (i >= w) r[i] = sgn & x[w-1];
    end
    return r;
  endfunction

  for (genvar m = 0; m < NL; m++) begin : g_lay
    localparam int NI  = NIN >> m;
    localparam int NO  = NI / 2;
    localparam int WIN = DATAW + FIRST + m;
    logic [NI*W-1:0] vin;
    logic [NO*W-1:0] vout;
    if (m == 0) begin : g_src
      assign vin = vals_i;
    end else begin : g_src
      assign vin = g_lay[m-1].vout;
    end
    for (genvar j = 0; j < NO; j++) begin : g_add
      assign vout[j*W +: W] = ext_from(vin[(2*j)*W +: W], WIN, sb_i.sgn)
                            + ext_from(vin[(2*j+1)*W +: W], WIN, sb_i.sgn);
    end
  end

  logic [NOUT*W-1:0] vals_d;
  assign vals_d = g_lay[NL-1].vout;

  if (REG_OUT != 0) begin : g_reg
    logic [NOUT*W-1:0] vals_q;
    beat_sb_t          sb_q;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        sb_q <= '0;
      end else if (en_i) begin
        sb_q <= sb_i;
      end
    end
    always_ff @(posedge clk_i) begin
      if (en_i) vals_q <= vals_d;
    end
    assign vals_o = vals_q;
    assign sb_o   = sb_q;
  end else begin : g_comb
    assign vals_o = vals_d;
    assign sb_o   = sb_i;
  end

endmodule

// File: rtl/acc_adder_tree.sv
// Pipelined signed/unsigned adder tree feeding a group accumulator with
// sticky overflow and a stallable output register.
module acc_adder_tree
  import acc_adder_tree_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = 8,
  parameter int ACCW       = 32,
  parameter int PIPE_EVERY = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [DATAW-1:0] data_i [NUM_INPUTS],
  input  logic             signed_i,
  input  logic             in_last_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [ACCW-1:0]  sum_o,
  output logic             overflow_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int L = $clog2(NUM_INPUTS);
  localparam int S = stage_count(L, PIPE_EVERY);
  localparam int W = DATAW + L;

  if (NUM_INPUTS < 1 || (NUM_INPUTS & (NUM_INPUTS - 1)) != 0) begin : g_chk_n
    $fatal(1, "acc_adder_tree: NUM_INPUTS must be a power of two");
  end
  if (ACCW < DATAW + L) begin : g_chk_w
    $fatal(1, "acc_adder_tree: ACCW too narrow for the tree result");
  end
  if (PIPE_EVERY < 1) begin : g_chk_p
    $fatal(1, "acc_adder_tree: PIPE_EVERY must be at least 1");
  end

  logic     en;
  beat_sb_t sb_in;
  beat_sb_t tree_sb;
  logic [W-1:0] tree_v;

  logic [ACCW-1:0] acc_q, acc_d, sum_q, sum_d;
  logic            first_q, first_d, ovf_acc_q, ovf_acc_d;
  logic            ovf_out_q, ovf_out_d, out_valid_q, out_valid_d;

  assign en         = !out_valid_q || out_ready_i;
  assign in_ready_o = en;
  assign sb_in      = '{sgn: signed_i, last: in_last_i, vld: in_valid_i};

  if (S == 0) begin : g_flat
    assign tree_v  = data_i[0];
    assign tree_sb = sb_in;
  end else begin : g_tree
    logic [NUM_INPUTS*W-1:0] entry;
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_entry
      assign entry[i*W +: W] = W'(data_i[i]);
    end
    for (genvar s = 0; s < S; s++) begin : g_st
      localparam int FIRST = s * PIPE_EVERY;
      localparam int NL    = (L - FIRST < PIPE_EVERY) ? (L - FIRST) : PIPE_EVERY;
      localparam int NIN   = NUM_INPUTS >> FIRST;
      localparam int NOUT  = NIN >> NL;
      logic [NIN*W-1:0]  vin;
      logic [NOUT*W-1:0] vout;
      beat_sb_t          sbin, sbout;
      if (s == 0) begin : g_src
        assign vin  = entry;
        assign sbin = sb_in;
      end else begin : g_src
        assign vin  = g_st[s-1].vout;
        assign sbin = g_st[s-1].sbout;
      end
      acc_adder_tree_stage #(
        .DATAW(DATAW), .W(W), .FIRST(FIRST), .NL(NL), .NIN(NIN), .REG_OUT(1)
      ) u_stage (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en_i  (en),
        .vals_i(vin),
        .sb_i  (sbin),
        .vals_o(vout),
        .sb_o  (sbout)
      );
    end
    assign tree_v  = g_st[S-1].vout;
    assign tree_sb = g_st[S-1].sbout;
  end

  function automatic logic [ACCW-1:0] ext_acc(input logic [W-1:0] x, input logic sgn);
    logic [ACCW-1:0] r;
    r        = '0;
    r[W-1:0] = x;
    for (int i = W; i < ACCW; i++) r[i] = sgn & x[W-1];
    return r;
  endfunction

  logic [ACCW-1:0] tree_ext, base;
  logic [ACCW:0]   add_full;
  logic            add_ov, ovf_grp;

  // Accumulator / output stage
  always_comb begin
    tree_ext = ext_acc(tree_v, tree_sb.sgn);
    base     = first_q ? '0 : acc_q;
    add_full = {1'b0, base} + {1'b0, tree_ext};
    add_ov   = tree_sb.sgn ? ((base[ACCW-1] == tree_ext[ACCW-1]) &&
                              (add_full[ACCW-1] != base[ACCW-1]))
                           : add_full[ACCW];
    ovf_grp  = (!first_q && ovf_acc_q) || add_ov;

    acc_d       = acc_q;
    first_d     = first_q;
    ovf_acc_d   = ovf_acc_q;
    sum_d       = sum_q;
    ovf_out_d   = ovf_out_q;
    out_valid_d = out_valid_q;
    if (en) begin
      out_valid_d = 1'b0;
      if (tree_sb.vld) begin
        if (tree_sb.last) begin
          sum_d       = add_full[ACCW-1:0];
          ovf_out_d   = ovf_grp;
          out_valid_d = 1'b1;
          acc_d       = '0;
          first_d     = 1'b1;
          ovf_acc_d   = 1'b0;
        end else begin
          acc_d     = add_full[ACCW-1:0];
          first_d   = 1'b0;
          ovf_acc_d = ovf_grp;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      ovf_acc_q   <= 1'b0;
      sum_q       <= '0;
      ovf_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      first_q     <= first_d;
      ovf_acc_q   <= ovf_acc_d;
      sum_q       <= sum_d;
      ovf_out_q   <= ovf_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum_o       = sum_q;
  assign overflow_o  = ovf_out_q;
  assign out_valid_o = out_valid_q;

endmodule
